// File: rtl/gtp_pkg.sv
// gtp_pkg: control-word field positions and arbiter state encoding shared by the GTP block path.
package gtp_pkg;
   localparam int CW_FLAG  = 15;
   localparam int CHAN_HI  = 14;
   localparam int CHAN_LO  = 9;
   localparam int LEN_HI   = 8;
   localparam int LEN_LO   = 0;
   localparam int DWLEN_HI = 8;
   localparam int DWLEN_LO = 1;
   localparam logic [15:0] CW_FILL = 16'h8000;
   typedef enum logic {IDLE, BODY} state_t;
endpackage

// File: rtl/gtp_block_arb.sv
// gtp_block_arb: round-robin drain of whole blocks from NCH GTP FIFOs into one 32-bit write stream.
module gtp_block_arb
   import gtp_pkg::*;
#(
   parameter int NCH = 4,
   parameter int TMO = 255
) (
   input  logic              gtp_clk,
   input  logic              rst,
   output logic [NCH-1:0]    give,
   input  logic [NCH-1:0]    have,
   input  logic [32*NCH-1:0] data,
   input  logic              out_full,
   output logic [31:0]       out_dat,
   output logic              out_wr,
   output logic              out_last,
   output logic [3:0]        out_chan,
   output logic              err_cw,
   output logic              err_tmo,
   output logic [31:0]       blk_cnt
);
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
   state_t state, state_n;
   logic [PW-1:0] ptr, ptr_n, ptr_inc;
   logic [7:0] rem, rem_n, tmo_cnt, tmo_n;
   logic [31:0] dw [NCH];
   logic [31:0] cur;
   logic xfer, tmo_hit, wr_n, last_n, ecw_n, etmo_n;
   for (genvar i = 0; i < NCH; i++) begin : g_dw
      assign dw[i] = data[32*i +: 32];
   end
   assign cur = dw[ptr];
   assign ptr_inc = (ptr == PW'(NCH-1)) ? '0 : ptr + 1'b1;
   assign tmo_hit = ({1'b0, tmo_cnt} + 9'd1) >= 9'(TMO);
   // give is also held low while reset is asserted so every output reads 0
   always_comb begin
      give = '0;
      if (rst && (state == IDLE || state == BODY) && !out_full) give[ptr] = 1'b1;
   end
   assign xfer = give[ptr] & have[ptr];
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      rem_n   = rem;
      tmo_n   = tmo_cnt;
      wr_n    = 1'b0;
      last_n  = 1'b0;
      ecw_n   = 1'b0;
      etmo_n  = 1'b0;
      if (!out_full) begin
         if (state == IDLE) begin
            if (!xfer) ptr_n = ptr_inc;
            else if (!cur[CW_FLAG]) begin
               ecw_n = 1'b1;
               ptr_n = ptr_inc;
            end else begin
               wr_n  = 1'b1;
               rem_n = cur[DWLEN_HI:DWLEN_LO];
               tmo_n = '0;
               if (cur[DWLEN_HI:DWLEN_LO] == 8'd0) begin
                  last_n = 1'b1;
                  ptr_n  = ptr_inc;
               end else state_n = BODY;
            end
         end else if (xfer) begin
            wr_n  = 1'b1;
            rem_n = rem - 8'd1;
            tmo_n = '0;
            if (rem == 8'd1) begin
               last_n  = 1'b1;
               ptr_n   = ptr_inc;
               state_n = IDLE;
            end
         end else if (tmo_hit) begin
            etmo_n  = 1'b1;
            tmo_n   = '0;
            ptr_n   = ptr_inc;
            state_n = IDLE;
         end else tmo_n = tmo_cnt + 8'd1;
      end
   end
   always_ff @(posedge gtp_clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ptr      <= '0;
         rem      <= '0;
         tmo_cnt  <= '0;
         out_dat  <= '0;
         out_wr   <= 1'b0;
         out_last <= 1'b0;
         out_chan <= '0;
         err_cw   <= 1'b0;
         err_tmo  <= 1'b0;
         blk_cnt  <= '0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         rem      <= rem_n;
         tmo_cnt  <= tmo_n;
         out_wr   <= wr_n;
         out_last <= last_n;
         err_cw   <= ecw_n;
         err_tmo  <= etmo_n;
         if (wr_n) begin
            out_dat  <= cur;
            out_chan <= 4'(ptr);
         end
         if (last_n) blk_cnt <= blk_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_gtp_block_arb.sv
// tb_gtp_block_arb: directed vector table plus reset-mid-block sequence for gtp_block_arb.
module tb_gtp_block_arb;
   logic gtp_clk = 1'b0;
   logic rst = 1'b0;
   logic out_full = 1'b0;
   logic [3:0] have = '0;
   logic [127:0] data = '0;
   logic [3:0] give, out_chan;
   logic [31:0] out_dat, blk_cnt;
   logic out_wr, out_last, err_cw, err_tmo;
   int n_chk = 0;
   int n_fail = 0;
   typedef struct {
      int rep;
      logic [3:0] have;
      logic [31:0] dat;
      logic full;
      logic [3:0] g;
      logic wr, last;
      logic [31:0] odat;
      logic [3:0] ch;
      logic ecw, etmo;
      logic [31:0] cnt;
   } vec_t;
   vec_t v[$];
   always #5 gtp_clk = ~gtp_clk;
   gtp_block_arb #(.NCH(4), .TMO(16)) dut (
      .gtp_clk(gtp_clk), .rst(rst), .give(give), .have(have), .data(data),
      .out_full(out_full), .out_dat(out_dat), .out_wr(out_wr), .out_last(out_last),
      .out_chan(out_chan), .err_cw(err_cw), .err_tmo(err_tmo), .blk_cnt(blk_cnt)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic vec_t mk(input int rep, input logic [3:0] h, input logic [31:0] d,
                               input logic f, input logic [3:0] g, input logic wr, input logic last,
                               input logic [31:0] od, input logic [3:0] ch, input logic ecw,
                               input logic etmo, input logic [31:0] cnt);
      vec_t t;
      t.rep = rep; t.have = h; t.dat = d; t.full = f; t.g = g; t.wr = wr; t.last = last;
      t.odat = od; t.ch = ch; t.ecw = ecw; t.etmo = etmo; t.cnt = cnt;
      return t;
   endfunction
   task automatic step(input vec_t t, input int idx);
      have = t.have;
      data = {4{t.dat}};
      out_full = t.full;
      #1 chk($sformatf("v%0d give", idx), 32'(give), 32'(t.g));
      @(posedge gtp_clk);
      #1;
      chk($sformatf("v%0d out_wr", idx), 32'(out_wr), 32'(t.wr));
      chk($sformatf("v%0d out_last", idx), 32'(out_last & out_wr), 32'(t.last));
      chk($sformatf("v%0d err_cw", idx), 32'(err_cw), 32'(t.ecw));
      chk($sformatf("v%0d err_tmo", idx), 32'(err_tmo), 32'(t.etmo));
      chk($sformatf("v%0d blk_cnt", idx), blk_cnt, t.cnt);
      if (t.wr) begin
         chk($sformatf("v%0d out_dat", idx), out_dat, t.odat);
         chk($sformatf("v%0d out_chan", idx), 32'(out_chan), 32'(t.ch));
      end
   endtask
   initial begin
      // ch0: CW with one body dword
      v.push_back(mk(1, 4'b0001, 32'h0000_8203, 0, 4'b0001, 1, 0, 32'h0000_8203, 0, 0, 0, 0));
      v.push_back(mk(1, 4'b0001, 32'hAAAA_0001, 0, 4'b0001, 1, 1, 32'hAAAA_0001, 0, 0, 0, 1));
      // ch1 and ch2 both ready; ch1 block must finish before ch2 starts
      v.push_back(mk(1, 4'b0110, 32'h0000_8206, 0, 4'b0010, 1, 0, 32'h0000_8206, 1, 0, 0, 1));
      v.push_back(mk(1, 4'b0110, 32'h1111_0001, 0, 4'b0010, 1, 0, 32'h1111_0001, 1, 0, 0, 1));
      v.push_back(mk(1, 4'b0110, 32'h1111_0002, 0, 4'b0010, 1, 0, 32'h1111_0002, 1, 0, 0, 1));
      v.push_back(mk(1, 4'b0110, 32'h1111_0003, 0, 4'b0010, 1, 1, 32'h1111_0003, 1, 0, 0, 2));
      v.push_back(mk(1, 4'b0100, 32'h0000_8406, 0, 4'b0100, 1, 0, 32'h0000_8406, 2, 0, 0, 2));
      v.push_back(mk(1, 4'b0100, 32'h2222_0001, 0, 4'b0100, 1, 0, 32'h2222_0001, 2, 0, 0, 2));
      v.push_back(mk(1, 4'b0100, 32'h2222_0002, 0, 4'b0100, 1, 0, 32'h2222_0002, 2, 0, 0, 2));
      v.push_back(mk(1, 4'b0100, 32'h2222_0003, 0, 4'b0100, 1, 1, 32'h2222_0003, 2, 0, 0, 3));
      // ch3 block stalled by out_full for 10 cycles mid-body
      v.push_back(mk(1, 4'b1000, 32'h0000_8606, 0, 4'b1000, 1, 0, 32'h0000_8606, 3, 0, 0, 3));
      v.push_back(mk(1, 4'b1000, 32'h3333_0001, 0, 4'b1000, 1, 0, 32'h3333_0001, 3, 0, 0, 3));
      v.push_back(mk(10, 4'b1000, 32'h3333_0002, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 3));
      v.push_back(mk(1, 4'b1000, 32'h3333_0002, 0, 4'b1000, 1, 0, 32'h3333_0002, 3, 0, 0, 3));
      v.push_back(mk(1, 4'b1000, 32'h3333_0003, 0, 4'b1000, 1, 1, 32'h3333_0003, 3, 0, 0, 4));
      // bad CW on ch0, then the next channels are polled each cycle
      v.push_back(mk(1, 4'b0001, 32'h0000_1234, 0, 4'b0001, 0, 0, 0, 0, 1, 0, 4));
      v.push_back(mk(1, 4'b0000, 32'h0, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 4));
      v.push_back(mk(1, 4'b0000, 32'h0, 0, 4'b0100, 0, 0, 0, 0, 0, 0, 4));
      // ch3 delivers 2 of 5 dwords then goes quiet: abort on the 16th idle cycle
      v.push_back(mk(1, 4'b1000, 32'h0000_8608, 0, 4'b1000, 1, 0, 32'h0000_8608, 3, 0, 0, 4));
      v.push_back(mk(1, 4'b1000, 32'h4444_0001, 0, 4'b1000, 1, 0, 32'h4444_0001, 3, 0, 0, 4));
      v.push_back(mk(15, 4'b0000, 32'h0, 0, 4'b1000, 0, 0, 0, 0, 0, 0, 4));
      v.push_back(mk(1, 4'b0000, 32'h0, 0, 4'b1000, 0, 0, 0, 0, 0, 1, 4));
      v.push_back(mk(1, 4'b0000, 32'h0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 4));
      // single-dword block (DWLEN=0) on ch1
      v.push_back(mk(1, 4'b0010, 32'h0000_8201, 0, 4'b0010, 1, 1, 32'h0000_8201, 1, 0, 0, 5));
      v.push_back(mk(1, 4'b0000, 32'h0, 0, 4'b0100, 0, 0, 0, 0, 0, 0, 5));
      #2;
      chk("reset give", 32'(give), 32'h0);
      chk("reset out_wr", 32'(out_wr), 32'h0);
      chk("reset blk_cnt", blk_cnt, 32'h0);
      #10 rst = 1'b1;
      foreach (v[k]) for (int r = 0; r < v[k].rep; r++) step(v[k], k);
      step(mk(1, 4'b1000, 32'h0000_8606, 0, 4'b1000, 1, 0, 32'h0000_8606, 3, 0, 0, 5), 99);
      #2 rst = 1'b0;
      #1;
      chk("async rst give", 32'(give), 32'h0);
      chk("async rst out_wr", 32'(out_wr), 32'h0);
      chk("async rst out_last", 32'(out_last), 32'h0);
      chk("async rst out_dat", out_dat, 32'h0);
      chk("async rst out_chan", 32'(out_chan), 32'h0);
      chk("async rst blk_cnt", blk_cnt, 32'h0);
      #1 rst = 1'b1;
      have = 4'b0000;
      #1 chk("post rst give", 32'(give), 32'h1);
      step(mk(1, 4'b0001, 32'h0000_8201, 0, 4'b0001, 1, 1, 32'h0000_8201, 0, 0, 0, 1), 100);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/gtp_block_arb.md
Name: gtp_block_arb

Overview:
- Round-robin arbiter downstream of the per-channel GTP block FIFOs. Drains whole blocks, one at a time, from NCH FIFOs using their give/have handshake.
- Each block starts with a CW dword. CW sits in bits [15:0]; format is 1 CCCCCC LLLLLLLLL.
- Forwards the blocks as a single 32-bit write stream toward the MIG write buffer, all on gtp_clk.
- Guarantees that blocks from different channels are never interleaved on the output.

Parameters:
- NCH, 4, number of source FIFOs (1..16).
- TMO, 255, max consecutive no-have cycles inside a block body before abort (8-bit).

Ports:
- gtp_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- give  out  NCH  one-hot read request to source FIFO i.
- have  in  NCH  FIFO i returns valid data in the same cycle as give.
- data  in  32*NCH  FIFO i dword on bits [32*i+31:32*i]; valid only when have[i].
- out_full  in  1  downstream almost-full; guarantees at least 1 free slot when asserted.
- out_dat  out  32  forwarded dword.
- out_wr  out  1  write strobe for out_dat.
- out_last  out  1  marks the final dword of a block (qualified by out_wr).
- out_chan  out  4  source FIFO index of the current out_dat.
- err_cw  out  1  one-cycle pulse: first dword lacked bit 15.
- err_tmo  out  1  one-cycle pulse: block body aborted by timeout.
- blk_cnt  out  32  count of fully forwarded blocks; wraps.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, ptr=0, remaining=0, tmo_cnt=0. All outputs 0: give, out_wr, out_last, out_dat, out_chan, err_cw, err_tmo, blk_cnt.
- give is combinational from registered state and out_full:
  - give[ptr] = (state is IDLE or BODY) & ~out_full.
  - All other give bits are 0; give is 0 in any other state.
- A transfer occurs in a cycle where give[ptr] & have[ptr] are both 1. Each transfer consumes exactly one source word.
- Transfer to output latency: out_wr, out_dat, out_chan, out_last are registered 1 cycle after the transfer.
- State IDLE:
  - out_full=1: hold ptr, no give.
  - No have: ptr <= (ptr+1) mod NCH.
  - Transfer with dat[15]=0: drop the word, pulse err_cw, ptr advances, stay IDLE. No output write.
  - Transfer with dat[15]=1: forward the dword, load remaining <= dat[8:1] (8-bit).
    - If remaining=0: out_last=1, blk_cnt++, ptr advances, stay IDLE.
    - Else: go to BODY with ptr locked and tmo_cnt=0.
- State BODY:
  - Transfer: forward dword, remaining--, tmo_cnt=0.
    - Last dword is the one taken when remaining==1: out_last=1, blk_cnt++, ptr advances, go to IDLE.
  - No have (out_full=0): tmo_cnt++. When tmo_cnt reaches TMO: pulse err_tmo, go to IDLE, ptr advances. The partial block is not marked last and blk_cnt is unchanged.
  - Cycles with out_full=1 do not count toward timeout.
- Bit 15 within body dwords is not checked here; the source FIFO owns that check.
- Channel fairness: at most one block per grant, then the grant rotates. An empty channel costs exactly one cycle.
- NCH=1: ptr stays 0 permanently.
- blk_cnt wraps from 0xFFFFFFFF to 0.
- Reset mid-block: state is discarded immediately; no out_last is emitted.

Decomposition:
- Shared package gtp_pkg holds:
  - CW field constants: CW_FLAG bit 15, CHAN [14:9], LEN [8:0], DWLEN [8:1].
  - The filler CW constant 16'h8000.
  - State encoding: IDLE, BODY.
- No sub-module; the round-robin pointer is a simple counter inline.

Test Plan:
- Single channel 0 supplies CW 0x8203 (L=3, DWLEN=1), then 1 body dword. Required: 2 out_wr, out_last on the 2nd, out_chan=0, blk_cnt=1.
- Channels 1 and 2 each hold one 4-dword block. Required: the ch1 block is output contiguously first, then ch2; no interleave; blk_cnt=2.
- out_full is held high for 10 cycles mid-body. Required: give=0 throughout, no out_wr, no err_tmo; resumes correctly when out_full drops.
- Channel 3 stops giving have after 2 of 5 dwords, with TMO=16. Required: err_tmo pulses exactly 16 idle cycles later; ptr moves to 0; blk_cnt unchanged.
- First dword 0x00001234 (bit 15 = 0). Required: err_cw pulses once, no out_wr, the next channel is polled the following cycle.
- rst is pulled low for one cycle while in BODY. Required: all outputs 0 asynchronously; after release, state is IDLE with ptr=0.
